// File: rtl/clk_tick_scheduler.sv
// Clock-tree divider controller: warm-up, run and drain-to-wrap sequencing of
// the divider start input, plus per-channel single-cycle tick strobes.
module clk_tick_scheduler #(
  parameter int NCH    = 4,
  parameter int WARMUP = 16
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           run_req_i,
  input  logic [7:0]     div_i,
  output logic           start_o,
  input  logic           cfg_we_i,
  input  logic [2:0]     cfg_ch_i,
  input  logic [2:0]     cfg_sel_i,
  input  logic           cfg_en_i,
  output logic [NCH-1:0] tick_o,
  output logic [1:0]     state_o
);

  localparam int CW = $clog2(WARMUP + 1);
  localparam logic [CW-1:0] WARM_LOAD = CW'(WARMUP);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    WARM  = 2'b01,
    RUN   = 2'b10,
    DRAIN = 2'b11
  } state_t;

  state_t          r_state;
  state_t          w_nextState;
  logic [CW-1:0]   r_warmCnt;
  logic            r_start;
  logic            w_startNext;
  logic            w_warmLoad;
  logic            w_running;

  logic [2:0]      r_sel [NCH];
  logic [NCH-1:0]  r_en;
  logic [NCH-1:0]  r_prev;
  logic [NCH-1:0]  r_tick;
  logic [NCH-1:0]  w_bit;
  logic [NCH-1:0]  w_hit;

  // The warm counter runs WARMUP cycles down to zero; the start edge follows
  // on the next edge, giving WARMUP+1 edges from the sampling of the request.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state   <= IDLE;
      r_start   <= 1'b0;
      r_warmCnt <= '0;
    end else begin
      r_state <= w_nextState;
      r_start <= w_startNext;
      if (w_warmLoad) begin
        r_warmCnt <= WARM_LOAD;
      end else if ((r_state == WARM) && (r_warmCnt != '0)) begin
        r_warmCnt <= r_warmCnt - CW'(1);
      end
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: begin
        if (run_req_i) w_nextState = WARM;
      end
      WARM: begin
        if (!run_req_i)             w_nextState = IDLE;
        else if (r_warmCnt == '0)   w_nextState = RUN;
      end
      RUN: begin
        if (!run_req_i) w_nextState = DRAIN;
      end
      DRAIN: begin
        if (run_req_i)               w_nextState = RUN;
        else if (div_i == 8'hFF)     w_nextState = IDLE;
      end
      default: w_nextState = IDLE;
    endcase
  end

  // Stopping on the 8'hFF sample lets the divider land exactly on its wrap to 0.
  always_comb begin
    w_startNext = (w_nextState == RUN) || (w_nextState == DRAIN);
    w_warmLoad  = (r_state == IDLE) && run_req_i;
    w_running   = (r_state == RUN) || (r_state == DRAIN);
  end

  always_comb begin
    w_bit = '0;
    w_hit = '0;
    for (int c = 0; c < NCH; c++) begin
      w_bit[c] = div_i[r_sel[c]];
      w_hit[c] = cfg_we_i && (cfg_ch_i == 3'(c));
    end
  end

  // A write preloads prev from the newly selected bit so a select change never
  // looks like a rising edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_en   <= '0;
      r_prev <= '0;
      r_tick <= '0;
      for (int c = 0; c < NCH; c++) begin
        r_sel[c] <= '0;
      end
    end else begin
      for (int c = 0; c < NCH; c++) begin
        if (w_hit[c]) begin
          r_sel[c]  <= cfg_sel_i;
          r_en[c]   <= cfg_en_i;
          r_prev[c] <= div_i[cfg_sel_i];
          r_tick[c] <= 1'b0;
        end else begin
          r_prev[c] <= w_bit[c];
          r_tick[c] <= r_en[c] & w_running & w_bit[c] & ~r_prev[c];
        end
      end
    end
  end

  assign start_o = r_start;
  assign tick_o  = r_tick;
  assign state_o = r_state;

endmodule
